level_edge_gen: RTL and testbench

Transmit side of the dual-edge signalling scheme. Turns one-cycle request ticks into transitions on a single `level` line. Every accepted request produces exactly one edge, either rising or falling. The block keeps `level` constant for at least `HOLD` cycles between edges, so a downstream Mealy or Moore dual-edge detector sees each edge and emits exactly one tick per edge. Requests that arrive during the hold window are queued in a saturating counter.

---
 rtl/level_edge_gen_pkg.sv | 16 +
 rtl/level_edge_gen_hold_timer.sv | 35 +++
 rtl/level_edge_gen.sv | 114 +++++++++++
 tb/tb_level_edge_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_edge_gen_pkg.sv
// Shared constants and sizing helpers for the dual-edge transmit generator.
package level_edge_gen_pkg;

    localparam int DEFAULT_HOLD   = 3;
    localparam int DEFAULT_PEND_W = 2;

    // Hold counter width: ceil(log2(hold)), never narrower than one bit.
    function automatic int cnt_width(input int hold);
        if (hold <= 2) begin
            return 1;
        end else begin
            return $clog2(hold);
        end
    endfunction

endpackage

// File: rtl/level_edge_gen_hold_timer.sv
// Hold-window timer: loads HOLD-1 on each edge and counts down to a done flag at zero.
module hold_timer
    import level_edge_gen_pkg::*;
#(
    parameter int HOLD = DEFAULT_HOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = cnt_width(HOLD);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // Counter register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == ZERO);

endmodule

// File: rtl/level_edge_gen.sv
// Dual-edge transmitter: each accepted request tick becomes one transition on level,
// spaced at least HOLD cycles apart, with a saturating queue for early requests.
module level_edge_gen
    import level_edge_gen_pkg::*;
#(
    parameter int HOLD   = DEFAULT_HOLD,
    parameter int PEND_W = DEFAULT_PEND_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};

    state_t            state_r, state_s;
    logic              level_r, level_s;
    logic              busy_r, busy_s;
    logic              overflow_r, overflow_s;
    logic [PEND_W-1:0] pending_r, pending_s;
    logic              load_s, dec_s, done_s;

    hold_timer #(.HOLD(HOLD)) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .dec   (dec_s),
        .done  (done_s)
    );

    // Next-state, edge generation and pending-queue bookkeeping.
    always_comb begin
        state_s    = state_r;
        level_s    = level_r;
        pending_s  = pending_r;
        overflow_s = 1'b0;
        load_s     = 1'b0;
        dec_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    level_s = ~level_r;
                    load_s  = 1'b1;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!done_s) begin
                    dec_s = 1'b1;
                    if (tick && (pending_r == PEND_MAX)) begin
                        overflow_s = 1'b1;
                    end else if (tick) begin
                        pending_s = pending_r + PEND_W'(1);
                    end else begin
                        pending_s = pending_r;
                    end
                end else if (pending_r != PEND_ZERO) begin
                    level_s = ~level_r;
                    load_s  = 1'b1;
                    // A fresh tick replaces the request being served: net zero.
                    if (tick) begin
                        pending_s = pending_r;
                    end else begin
                        pending_s = pending_r - PEND_W'(1);
                    end
                end else if (tick) begin
                    level_s = ~level_r;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_HOLD) || (pending_s != PEND_ZERO);
    end

    // State and registered outputs; reset discards queued requests and drops level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            level_r    <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
            pending_r  <= PEND_ZERO;
        end else begin
            state_r    <= state_s;
            level_r    <= level_s;
            busy_r     <= busy_s;
            overflow_r <= overflow_s;
            pending_r  <= pending_s;
        end
    end

    assign level    = level_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign pending  = pending_r;

endmodule

// File: tb/tb_level_edge_gen.sv
// Self-checking bench: two generator instances (HOLD=3 and HOLD=1) against a
// time-since-last-edge reference model, plus Moore/Mealy loopback counting.
module tb_level_edge_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick0 = 1'b0, tick1 = 1'b0;
    logic       level0, busy0, ovf0, level1, busy1, ovf1;
    logic [1:0] pend0, pend1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    int hold_v[2] = '{3, 1};
    int cap_v[2]  = '{3, 3};
    int m_level[2], m_owed[2], m_since[2], m_ovf[2];

    level_edge_gen #(.HOLD(3), .PEND_W(2)) dut0 (
        .clk(clk), .reset(reset), .tick(tick0),
        .level(level0), .busy(busy0), .pending(pend0), .overflow(ovf0));

    level_edge_gen #(.HOLD(1), .PEND_W(2)) dut1 (
        .clk(clk), .reset(reset), .tick(tick1),
        .level(level1), .busy(busy1), .pending(pend1), .overflow(ovf1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transition is allowed once HOLD edges have passed since the last one.
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_level[i] = 0; m_owed[i] = 0; m_since[i] = hold_v[i] + 1; m_ovf[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit t);
        m_ovf[i] = 0;
        if (m_since[i] >= hold_v[i]) begin
            if (m_owed[i] > 0) begin
                m_level[i] = 1 - m_level[i];
                m_since[i] = 1;
                if (!t) m_owed[i] = m_owed[i] - 1;
            end else if (t) begin
                m_level[i] = 1 - m_level[i];
                m_since[i] = 1;
            end else if (m_since[i] <= hold_v[i]) begin
                m_since[i] = m_since[i] + 1;
            end
        end else begin
            m_since[i] = m_since[i] + 1;
            if (t) begin
                if (m_owed[i] == cap_v[i]) m_ovf[i] = 1;
                else m_owed[i] = m_owed[i] + 1;
            end
        end
    endtask

    function automatic int m_busy(input int i);
        return ((m_owed[i] > 0) || (m_since[i] <= hold_v[i])) ? 1 : 0;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("level0", int'(level0), m_level[0]);
            chk("busy0", int'(busy0), m_busy(0));
            chk("pending0", int'(pend0), m_owed[0]);
            chk("overflow0", int'(ovf0), m_ovf[0]);
            chk("level1", int'(level1), m_level[1]);
            chk("busy1", int'(busy1), m_busy(1));
            chk("pending1", int'(pend1), m_owed[1]);
            chk("overflow1", int'(ovf1), m_ovf[1]);
        end
    end

    // Downstream Mealy and Moore dual-edge detectors on instance 0, plus overflow tally.
    logic prev_r = 1'b0;
    logic moore_tick_r = 1'b0;
    int   mealy_cnt = 0, moore_cnt = 0, ovf_cnt = 0;
    always @(posedge clk) begin
        prev_r       <= level0;
        mealy_cnt    <= mealy_cnt + int'(level0 ^ prev_r);
        moore_tick_r <= level0 ^ prev_r;
        moore_cnt    <= moore_cnt + int'(moore_tick_r);
        ovf_cnt      <= ovf_cnt + int'(ovf0);
    end

    task automatic cyc(input bit t0, input bit t1);
        tick0 = t0;
        tick1 = t1;
        @(posedge clk);
        model_step(0, t0);
        model_step(1, t1);
        @(negedge clk);
        tick0 = 1'b0;
        tick1 = 1'b0;
    endtask

    task automatic do_reset();
        cmp_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cmp_en = 1'b1;
    endtask

    initial begin
        int snap_mealy, snap_moore, snap_ovf, n, lv;
        model_reset();
        #1;
        chk("reset_level", int'(level0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_pending", int'(pend0), 0);
        chk("reset_overflow", int'(ovf0), 0);
        do_reset();

        // Single tick: busy for three edges, idle after the fourth.
        cyc(1'b1, 1'b0);
        chk("single_level", int'(level0), 1);
        chk("single_busy_k", int'(busy0), 1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("single_busy_k2", int'(busy0), 1);
        cyc(1'b0, 1'b0);
        chk("single_busy_k3", int'(busy0), 0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        chk("single_level_end", int'(level0), 1);

        // Burst of three: pending peaks at 2, busy falls after k+9.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("burst_pending_peak", int'(pend0), 2);
        for (int i = 3; i <= 8; i++) cyc(1'b0, 1'b0);
        chk("burst_busy_k8", int'(busy0), 1);
        cyc(1'b0, 1'b0);
        chk("burst_busy_k9", int'(busy0), 0);
        chk("burst_final_level", int'(level0), 1);

        // Overflow: six back-to-back ticks, one dropped.
        do_reset();
        snap_mealy = mealy_cnt;
        cyc(1'b1, 1'b0);
        chk("ovf_pend_k", int'(pend0), 0);
        cyc(1'b1, 1'b0); chk("ovf_pend_k1", int'(pend0), 1);
        cyc(1'b1, 1'b0); chk("ovf_pend_k2", int'(pend0), 2);
        cyc(1'b1, 1'b0); chk("ovf_pend_k3", int'(pend0), 2);
        cyc(1'b1, 1'b0); chk("ovf_pend_k4", int'(pend0), 3);
        chk("ovf_pulse_k4", int'(ovf0), 0);
        cyc(1'b1, 1'b0); chk("ovf_pend_k5", int'(pend0), 3);
        chk("ovf_pulse_k5", int'(ovf0), 1);
        cyc(1'b0, 1'b0);
        chk("ovf_pulse_k6", int'(ovf0), 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
        chk("ovf_transitions", mealy_cnt - snap_mealy, 5);
        chk("ovf_final_level", int'(level0), 1);

        // Reset in the middle of a hold window with two requests queued.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("rst_pre_pending", int'(pend0), 2);
        chk("rst_pre_level", int'(level0), 1);
        cmp_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_level", int'(level0), 0);
        chk("rst_async_pending", int'(pend0), 0);
        chk("rst_async_busy", int'(busy0), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        cyc(1'b0, 1'b0);
        snap_mealy = mealy_cnt;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        chk("rst_no_transitions", mealy_cnt - snap_mealy, 0);

        // HOLD=1 instance: toggles on every cycle while tick is held.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            lv = (i + 1) % 2;
            chk("hold1_level", int'(level1), lv);
            chk("hold1_pending", int'(pend1), 0);
            chk("hold1_overflow", int'(ovf1), 0);
        end

        // Loopback: 200 random requests, every one is an edge or an overflow.
        do_reset();
        cyc(1'b0, 1'b0);
        snap_mealy = mealy_cnt;
        snap_moore = moore_cnt;
        snap_ovf   = ovf_cnt;
        n = 0;
        for (int i = 0; i < 5000 && n < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                cyc(1'b1, ($urandom_range(0, 1) == 1));
                n++;
            end else begin
                cyc(1'b0, ($urandom_range(0, 1) == 1));
            end
        end
        chk("loop_ticks_issued", n, 200);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);
        chk("loop_mealy", (mealy_cnt - snap_mealy) + (ovf_cnt - snap_ovf), 200);
        chk("loop_moore", (moore_cnt - snap_moore) + (ovf_cnt - snap_ovf), 200);
        chk("loop_idle", int'(busy0), 0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
